// File: rtl/instr_exec_unit.sv
// Single-issue execution unit: one-cycle ALU/multiply ops plus an
// iterative restoring divider for DIV/MOD, behind valid/ready handshakes.
module instr_exec_unit #(
    parameter int OP_WIDTH   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_opc,
    input  logic [OP_WIDTH-1:0]     in_op_a,
    input  logic [OP_WIDTH-1:0]     in_op_b,
    input  logic [ADDR_WIDTH-1:0]   in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*OP_WIDTH-1:0]   out_result,
    output logic [ADDR_WIDTH-1:0]   out_tag,
    output logic                    out_div0,
    output logic                    busy
);

    localparam int RW = 2 * OP_WIDTH;
    localparam int CW = $clog2(OP_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OP_WIDTH);

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;

    typedef enum logic [1:0] {IDLE, DIVIDE, HOLD} state_t;

    state_t state, state_n;

    logic [RW-1:0]         res_q;
    logic [ADDR_WIDTH-1:0] tag_q;
    logic                  div0_q;
    logic [OP_WIDTH-1:0]   rem_q, quo_q, dsr_q;
    logic [CW-1:0]         cnt_q;
    logic                  neg_a_q, neg_b_q, is_mod_q;

    logic                  accept, is_divmod, start_div;
    logic signed [RW-1:0]  a_ext, b_ext;
    logic [RW-1:0]         alu_res;
    logic [OP_WIDTH-1:0]   a_mag, b_mag;
    logic [OP_WIDTH:0]     trial;
    logic [RW-1:0]         fin_ext;
    logic                  fin_neg;

    assign a_ext     = RW'(signed'(in_op_a));
    assign b_ext     = RW'(signed'(in_op_b));
    assign a_mag     = in_op_a[OP_WIDTH-1] ? -in_op_a : in_op_a;
    assign b_mag     = in_op_b[OP_WIDTH-1] ? -in_op_b : in_op_b;
    assign is_divmod = (in_opc == OPC_DIV) || (in_opc == OPC_MOD);
    assign start_div = is_divmod && (|in_op_b);
    assign accept    = in_valid && in_ready;

    assign trial   = {rem_q, quo_q[OP_WIDTH-1]} - {1'b0, dsr_q};
    assign fin_ext = {{OP_WIDTH{1'b0}}, (is_mod_q ? rem_q : quo_q)};
    assign fin_neg = is_mod_q ? neg_a_q : (neg_a_q ^ neg_b_q);

    always_comb begin
        alu_res = '0;
        unique case (in_opc)
            OPC_ZERO:  alu_res = '0;
            OPC_PASSA: alu_res = a_ext;
            OPC_PASSB: alu_res = b_ext;
            OPC_ADD:   alu_res = a_ext + b_ext;
            OPC_SUB:   alu_res = a_ext - b_ext;
            OPC_MULT:  alu_res = a_ext * b_ext;
            OPC_DIV:   alu_res = '0;
            OPC_MOD:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // HOLD accepts a follow-on instruction in the same edge the result drains
    always_comb begin
        state_n   = state;
        out_valid = (state == HOLD);
        in_ready  = (state != DIVIDE) && (!out_valid || out_ready);
        busy      = (state == DIVIDE) && (cnt_q != CNT_LAST);
        unique case (state)
            IDLE: begin
                if (accept) state_n = start_div ? DIVIDE : HOLD;
            end
            DIVIDE: begin
                if (cnt_q == CNT_LAST) state_n = HOLD;
            end
            HOLD: begin
                if (accept)         state_n = start_div ? DIVIDE : HOLD;
                else if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q    <= '0;
            tag_q    <= '0;
            div0_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_mod_q <= 1'b0;
        end else if (accept) begin
            tag_q  <= in_tag;
            div0_q <= is_divmod && !start_div;
            if (start_div) begin
                rem_q    <= '0;
                quo_q    <= a_mag;
                dsr_q    <= b_mag;
                cnt_q    <= '0;
                neg_a_q  <= in_op_a[OP_WIDTH-1];
                neg_b_q  <= in_op_b[OP_WIDTH-1];
                is_mod_q <= (in_opc == OPC_MOD);
            end else begin
                res_q <= alu_res;
            end
        end else if (state == DIVIDE) begin
            if (cnt_q == CNT_LAST) begin
                res_q <= fin_neg ? -fin_ext : fin_ext;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (!trial[OP_WIDTH]) begin
                    rem_q <= trial[OP_WIDTH-1:0];
                    quo_q <= {quo_q[OP_WIDTH-2:0], 1'b1};
                end else begin
                    rem_q <= {rem_q[OP_WIDTH-2:0], quo_q[OP_WIDTH-1]};
                    quo_q <= {quo_q[OP_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign out_result = res_q;
    assign out_tag    = tag_q;
    assign out_div0   = div0_q;

endmodule
